// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter granting one shared resource to one of 8 requesters
//   clk         - system clock, all state updates on rising edge
//   rst_n       - synchronous active-low reset
//   req_i       - level-sensitive request vector, bit i = requester i
//   done_i      - release strobe from the current owner (ignored when idle)
//   gnt_o       - registered one-hot grant, zero when no grant
//   gnt_idx_o   - index of current owner, holds last value when idle
//   gnt_valid_o - high while a grant is active
//   timeout_o   - one-cycle pulse after a grant was revoked by the hold limit
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       timeout_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        gnt_q, gnt_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              to_q, to_d;
    logic [2:0]        win;
    logic              rel, forced;
    // Scan from the farthest offset down so the closest set bit to ptr wins
    always_comb begin
        win = ptr_q;
        for (int k = 7; k >= 0; k--)
            if (req_i[ptr_q + 3'(k)]) win = ptr_q + 3'(k);
    end
    // done and withdrawal take precedence, so a forced release never coincides with them
    assign rel    = done_i || !req_i[idx_q];
    assign forced = !rel && (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD));
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        if (state_q == IDLE) begin
            if (|req_i) begin
                state_d = GRANT;
                idx_d   = win;
                gnt_d   = 8'b1 << win;
                cnt_d   = HOLD_W'(1);
            end
        end else if (rel || forced) begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            ptr_d   = idx_q + 3'd1;
            to_d    = forced;
        end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + HOLD_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            gnt_q   <= 8'h00;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end
    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = (state_q == GRANT);
    assign timeout_o   = to_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    int         n_chk = 0;
    int         n_fail = 0;
    rr_arbiter_8 #(.MAX_HOLD(15), .HOLD_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_i(req),
        .done_i(done),
        .gnt_o(gnt),
        .gnt_idx_o(gnt_idx),
        .gnt_valid_o(gnt_valid),
        .timeout_o(timeout)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_gnt(input string tag, input logic [2:0] idx);
        chk({tag, "_gnt"}, 32'(gnt), 32'(8'b1 << idx));
        chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        chk({tag, "_vld"}, 32'(gnt_valid), 32'd1);
        chk({tag, "_to"}, 32'(timeout), 32'd0);
    endtask
    task automatic chk_idle(input string tag, input logic to);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_vld"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_to"}, 32'(timeout), 32'(to));
    endtask
    initial begin
        // reset and single requester
        tick();
        tick();
        chk_idle("rst", 1'b0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        rst_n = 1'b1;
        req = 8'h04;
        tick();
        chk_gnt("single", 3'd2);
        done = 1'b1;
        tick();
        chk_idle("single_rel", 1'b0);
        chk("single_rel_idx", 32'(gnt_idx), 32'd2);
        done = 1'b0;
        req = 8'h00;
        tick();
        // done ignored while idle
        done = 1'b1;
        tick();
        chk_idle("idle_done", 1'b0);
        done = 1'b0;
        // full round-robin from ptr 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'hFF;
        done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_gnt($sformatf("rr%0d", i), 3'(i % 8));
            tick();
            chk_idle($sformatf("rr_gap%0d", i), 1'b0);
        end
        done = 1'b0;
        // pointer wrap: grant 6, then 7 beats 0, then 0 beats 7
        req = 8'h40;
        tick();
        chk_gnt("wrap6", 3'd6);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h81;
        tick();
        chk_gnt("wrap7", 3'd7);
        done = 1'b1;
        tick();
        chk_idle("wrap7_rel", 1'b0);
        done = 1'b0;
        tick();
        chk_gnt("wrap0", 3'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h00;
        tick();
        // hold limit: 15 grant cycles then forced release
        req = 8'h10;
        tick();
        chk_gnt("hold1", 3'd4);
        for (int i = 2; i <= 15; i++) begin
            tick();
            chk_gnt($sformatf("hold%0d", i), 3'd4);
        end
        tick();
        chk_idle("timeout", 1'b1);
        tick();
        chk_gnt("regrant", 3'd4);
        // done in the limit cycle wins, no timeout
        for (int i = 2; i <= 15; i++) tick();
        chk_gnt("hold15b", 3'd4);
        done = 1'b1;
        tick();
        chk_idle("done_limit", 1'b0);
        done = 1'b0;
        tick();
        chk_gnt("regrant2", 3'd4);
        // withdrawal
        tick();
        req = 8'h00;
        tick();
        chk_idle("withdraw", 1'b0);
        tick();
        chk_idle("withdraw2", 1'b0);
        // reset mid-grant, ptr back to 0
        req = 8'h20;
        tick();
        chk_gnt("own5", 3'd5);
        rst_n = 1'b0;
        tick();
        chk_idle("rst_mid", 1'b0);
        chk("rst_mid_idx", 32'(gnt_idx), 32'd0);
        rst_n = 1'b1;
        req = 8'h30;
        tick();
        chk_gnt("post_rst", 3'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Selects a winner index, then drives a one-hot grant through the team's 3-to-8 decode (bit `i` of the grant set when the index equals `i`).
- Holds the grant until the owner releases it, drops its request, or exceeds a configurable hold limit.
- Sits between requesting masters and a shared bus or port select.

Parameters:
- MAX_HOLD, 15: maximum consecutive grant cycles per owner; 0 disables the limit.
- HOLD_W, 4: hold-counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on clk rising edge only.
- req  input  8  request vector; bit i = requester i wants the resource; level-sensitive.
- done  input  1  release strobe from the current owner; ignored when gnt_valid=0.
- gnt  output  8  one-hot grant, registered; all-zero when no grant; equals decode(gnt_idx) when gnt_valid=1.
- gnt_idx  output  3  index of current owner; holds its last value when gnt_valid=0.
- gnt_valid  output  1  1 while a grant is active.
- timeout  output  1  one-cycle pulse: the previous grant was revoked by the hold limit.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=3'd0, hold counter=0, state=IDLE.
  - Reset applied mid-grant revokes the grant on that edge with no timeout pulse.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0: winner = first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Next edge: gnt_idx=winner, gnt=decode(winner), gnt_valid=1, counter=1, state=GRANT.
  - Latency is one cycle from req sampled to gnt visible.
  - If req == 0: remain in IDLE with gnt=0.
- GRANT: evaluated each cycle, first match wins.
  - a) done=1 → release, normal.
  - b) req[gnt_idx]=0 → release, normal (requester withdrew).
  - c) MAX_HOLD!=0 and counter==MAX_HOLD → release, forced.
  - d) otherwise hold the grant and increment the counter. The counter saturates and never wraps.
- Release takes effect on the next edge:
  - gnt=0, gnt_valid=0, state=IDLE.
  - ptr=gnt_idx+1 mod 8 (index 7 wraps to 0).
  - timeout=1 for exactly that cycle only if the release was forced.
- After every release the arbiter spends one mandatory IDLE cycle, so a new grant appears 2 cycles after the release cycle. Back-to-back grants to different owners therefore have a 1-cycle gap.
- done and the hold limit in the same cycle: done wins, timeout=0.
- Requests changing while in GRANT do not affect the current owner. Only req[gnt_idx] is examined.
- A released owner still requesting is re-granted only after all other active requesters have been scanned past (round-robin fairness).
- gnt never has more than one bit set. gnt_valid=1 iff gnt!=0.
- done while in IDLE is ignored.
- timeout is 0 in all cycles except the forced-release IDLE cycle.

Test Plan:
1. Reset then single requester: rst_n=0 for 2 cycles, release, req=8'h04 → one cycle later gnt=8'h04, gnt_idx=2, gnt_valid=1. After done pulse → next cycle gnt=0, ptr=3.
2. Round-robin: req=8'hFF held, done pulsed in every grant cycle → grant sequence idx 0,1,2,…,7,0 with a 1-cycle gap (gnt=0) between each. No index is skipped or repeated.
3. Pointer wrap and fairness: ptr=7 (after granting 6), req=8'h81 → grant idx 7. Release → next grant idx 0, not 7.
4. Timeout: MAX_HOLD=15, req=8'h10 held, no done → gnt=8'h10 for exactly 15 cycles, then gnt=0 with timeout=1 for one cycle. Next grant idx 4 again after the IDLE cycle, since it is the only requester.
5. Simultaneous done and limit: done asserted in the 15th grant cycle → release with timeout=0. Withdrawal: req[gnt_idx] dropped mid-grant → gnt=0 next cycle, timeout=0.
6. Reset mid-grant: owner idx 5 active, rst_n=0 for one edge → gnt=0, gnt_idx=0, timeout=0. After release with req=8'h30 → grant idx 4, because ptr was reset to 0.
